// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, ROM latency absorption, 3-entry queue to decode
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  halt
);
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  inflight;
    logic [1:0]            count;
    logic [DATA_WIDTH-1:0] q_data [3];
    logic [ADDR_WIDTH-1:0] q_pc   [3];

    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [2:0]            occupancy;
    logic [1:0]            widx;
    logic [1:0]            count_n;
    logic [DATA_WIDTH-1:0] q_data_n [3];
    logic [ADDR_WIDTH-1:0] q_pc_n   [3];

    // The ROM address comes straight from the PC flop; the head entry is the output.
    assign rom_addr   = pc;
    assign inst_out   = q_data[0];
    assign inst_pc    = q_pc[0];
    assign inst_valid = (count != 2'd0);

    // Issue only when queued plus outstanding words leave room for the reply; registered state only.
    always_comb begin
        occupancy = {1'b0, count} + {2'b00, inflight};
        issue     = !reset && !halt && !branch_valid && (occupancy <= 3'd2);
        push      = inflight && !branch_valid;
        pop       = inst_valid && inst_ready;
    end

    // Shift-down queue: entry 0 is the head, a pop shifts, a push lands behind the survivors.
    always_comb begin
        q_data_n = q_data;
        q_pc_n   = q_pc;
        count_n  = count;
        widx     = count - {1'b0, pop};
        if (branch_valid) begin
            count_n = 2'd0;
        end else begin
            if (pop) begin
                q_data_n[0] = q_data[1];
                q_data_n[1] = q_data[2];
                q_pc_n[0]   = q_pc[1];
                q_pc_n[1]   = q_pc[2];
            end
            if (push) begin
                for (int i = 0; i < 3; i++) begin
                    if (widx == 2'(i)) begin
                        q_data_n[i] = rom_data;
                        q_pc_n[i]   = req_pc;
                    end
                end
            end
            count_n = count + {1'b0, push} - {1'b0, pop};
        end
    end

    // PC, outstanding-read tracking and queue storage; a redirect overrides issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            count    <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else begin
            count    <= count_n;
            q_data   <= q_data_n;
            q_pc     <= q_pc_n;
            inflight <= issue;
            if (issue) begin
                req_pc <= pc;
            end
            if (branch_valid) begin
                pc <= branch_target;
            end else if (issue) begin
                pc <= pc + ADDR_WIDTH'(1);
            end
        end
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the synchronous instruction ROM and directly downstream-facing to decode.
- Owns the program counter and drives the ROM address.
- Absorbs the ROM's fixed 1-cycle read latency, buffers returned words in a 3-entry queue and presents {instruction, pc} to decode through a valid/ready handshake.
- Handles branch redirects (flush) and halt (stop issuing, drain).

Parameters:
- ADDR_WIDTH, 8, PC / ROM address width; PC wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32, instruction word width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rom_addr  out  ADDR_WIDTH  ROM read address; driven straight from the PC flop.
- rom_data  in  DATA_WIDTH  ROM read data; valid in cycle t+1 for the address presented in cycle t.
- inst_out  out  DATA_WIDTH  instruction at the queue head.
- inst_pc  out  ADDR_WIDTH  address of inst_out.
- inst_valid  out  1  queue head holds a valid entry.
- inst_ready  in  1  decode accepts the head; pop = inst_valid & inst_ready.
- branch_valid  in  1  redirect request, 1-cycle pulse or level.
- branch_target  in  ADDR_WIDTH  redirect address.
- halt  in  1  suppress new ROM reads while high.

Behaviour:
- Reset values: pc=RESET_PC, rom_addr=RESET_PC, inflight=0, count=0, inst_valid=0, inst_out=0, inst_pc=0.
- Issue rule: a read is issued in cycle t iff !reset & !halt & !branch_valid & (count + inflight) <= 2.
- The rule uses registered state only; there is no combinational path from inst_ready to rom_addr.
- On issue: inflight<=1, req_pc<=pc, pc<=pc+1 (0xFF wraps to 0x00). Otherwise inflight<=0 and pc holds.
- Return: if inflight=1 in cycle t+1, {rom_data, req_pc} is pushed to the queue at the end of t+1.
- Queue: 3-entry FIFO with registered head.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - The issue rule guarantees no push into a full queue.
  - A push into an empty queue gives inst_valid=1 in the next cycle.
- Throughput: with inst_ready held high, one instruction per cycle in steady state.
- Startup: after reset deasserts, RESET_PC is issued in cycle 0, returns in cycle 1, and inst_valid=1 with inst_pc=RESET_PC in cycle 2.
- Handshake: while inst_valid=1 and inst_ready=0, inst_out and inst_pc hold stable.
- Redirect (branch_valid=1 in cycle t) takes priority over everything:
  - queue cleared (count<=0, inst_valid<=0), even if a pop occurs in cycle t;
  - any inflight response is discarded; no new issue in t;
  - pc<=branch_target.
  - Target is issued in t+1, returns in t+2, inst_valid=1 in t+3.
- Redirect while halt=1: pc is still updated and the queue still flushed; issue waits for halt=0.
- Halt: no issues. An outstanding read still completes into the queue, and the queue still drains to decode. Issue resumes the cycle after halt falls.
- Reset mid-operation: immediate return to reset values. Any ROM data arriving after reset is ignored because inflight=0.

Test Plan:
- Release reset with inst_ready=1 and ROM words 0x00000001, 0x00000003, 0x04000403 at addresses 0-2 -> inst_valid first high in cycle 2; pc/inst pairs 0/0x00000001, 1/0x00000003, 2/0x04000403 appear on consecutive cycles.
- Hold inst_ready=0 from cycle 0 -> rom_addr stops advancing at 3; queue holds pcs 0,1,2 with inst_pc=0 stable. Raise inst_ready -> pcs 0,1,2,3,... follow with no gap or duplicate.
- Pulse branch_valid with branch_target=0x20 while the queue holds 2 entries and a read is inflight -> inst_valid=0 next cycle; old entries never appear; inst_valid=1 with inst_pc=0x20 exactly 3 cycles after the pulse.
- Branch to 0xFE with inst_ready=1 -> inst_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- Assert halt for 5 cycles with inst_ready=1 -> the inflight word is delivered, then inst_valid=0; rom_addr is constant during halt; fetch restarts at the next sequential pc after halt falls.
- Assert reset while inst_valid=1 -> all outputs return to reset values asynchronously, and the post-reset sequence restarts at RESET_PC.
